// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared types and constants for the 3x3 convolution front end.
//   PIX_W / W_W   : pixel and weight widths
//   KSIZE / NTAPS : kernel edge length and tap count (k = 3*row + col)
//   phase_e       : 4-phase frame position, mirrors the MAC count
//   col_t         : one window column, packed {bot, mid, top}
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int PIX_W = 8;
    localparam int W_W   = 8;
    localparam int KSIZE = 3;
    localparam int NTAPS = KSIZE * KSIZE;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_C0   = 2'd1,
        PH_C1   = 2'd2,
        PH_C2   = 2'd3
    } phase_e;

    typedef logic [3:0]              tap_idx_t;
    typedef logic [PIX_W-1:0]        pix_t;
    typedef logic signed [W_W-1:0]   wgt_t;

    // Bottom row sits in the MSBs so a column drops straight onto the MAC data bus.
    typedef struct packed {
        pix_t bot;
        pix_t mid;
        pix_t top;
    } col_t;

endpackage

// File: rtl/conv_window_feeder_if.sv
// ---------------------------------------------------------------------------
// conv_window_feeder_if
// Bundles the pixel stream, the weight-programming bus and the MAC-facing
// outputs of conv_window_feeder.
//   pix_in/pix_valid/pix_ready : raster pixel stream (valid/ready)
//   w_we/w_addr/w_data/w_commit: shadow weight writes and commit request
//   data/weight/phase          : one window column per cycle to the MAC
//   win_valid                  : current frame carries a complete window
//   res_strobe/res_x/res_y     : MAC result valid, with window centre coords
// Modports: slave = the feeder, master = the pixel/weight source and sink.
// ---------------------------------------------------------------------------
interface conv_window_feeder_if #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
);
    import conv_pkg::*;

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [PIX_W-1:0]       pix_in;
    logic                   pix_valid;
    logic                   pix_ready;
    logic                   w_we;
    tap_idx_t               w_addr;
    logic [W_W-1:0]         w_data;
    logic                   w_commit;
    logic [3*PIX_W-1:0]     data;
    logic [3*W_W-1:0]       weight;
    logic [1:0]             phase;
    logic                   win_valid;
    logic                   res_strobe;
    logic [XW-1:0]          res_x;
    logic [YW-1:0]          res_y;

    modport slave (
        input  pix_in, pix_valid, w_we, w_addr, w_data, w_commit,
        output pix_ready, data, weight, phase, win_valid, res_strobe, res_x, res_y
    );

    modport master (
        output pix_in, pix_valid, w_we, w_addr, w_data, w_commit,
        input  pix_ready, data, weight, phase, win_valid, res_strobe, res_x, res_y
    );

endinterface

// File: rtl/conv_line_ram.sv
// ---------------------------------------------------------------------------
// conv_line_ram
// One line of pixel storage: DEPTH x WIDTH, one asynchronous read and one
// synchronous write sharing the same address. The read returns the old word
// in the cycle it is overwritten (read-before-write).
//   clk   : clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : word written at the edge when we=1
//   rdata : current contents at addr
// ---------------------------------------------------------------------------
module conv_line_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // NOTE: storage arrays carry no reset; the window logic never uses a line
    // until it has been written since reset, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// ---------------------------------------------------------------------------
// conv_window_feeder
// Upstream feeder for the 3-tap-per-cycle MAC of the 3x3 convolution.
// Accepts at most one raster pixel per 4-cycle frame, keeps the two previous
// lines in line RAMs, builds a 3x3 window and presents one window column
// (with its weight column) in each of phases 1..3. The cycle after phase 3 of
// a complete-window frame is flagged with res_strobe and the window centre.
//   clk : clock
//   rst : asynchronous, active-high reset
//   bus : conv_window_feeder_if.slave (pixel stream, weight bus, MAC side)
// ---------------------------------------------------------------------------
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_window_feeder_if.slave  bus
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    phase_e          phase_q, phase_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    col_t            win_q [KSIZE];
    col_t            win_d [KSIZE];
    logic            win_valid_q, win_valid_d;
    logic [XW-1:0]   win_x_q, win_x_d;
    logic [YW-1:0]   win_y_q, win_y_d;
    logic            res_strobe_q, res_strobe_d;
    logic [XW-1:0]   res_x_q, res_x_d;
    logic [YW-1:0]   res_y_q, res_y_d;
    wgt_t            shadow_q [NTAPS];
    wgt_t            shadow_d [NTAPS];
    wgt_t            active_q [NTAPS];
    wgt_t            active_d [NTAPS];
    logic            commit_pend_q, commit_pend_d;

    logic            accept;
    logic            commit_load;
    pix_t            lb0_rd, lb1_rd;
    logic [3*PIX_W-1:0] data;
    logic [3*W_W-1:0]   weight;

    assign accept = bus.pix_valid && (phase_q == PH_IDLE);

    // lb0 holds the previous line, lb1 the one before it. On an accept the
    // column shifts up one line through both RAMs.
    conv_line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (x_q),
        .wdata (bus.pix_in),
        .rdata (lb0_rd)
    );

    conv_line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (x_q),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Phase, raster position, window and result bookkeeping.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        phase_d      = phase_e'(phase_q + 2'd1);
        x_d          = x_q;
        y_d          = y_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        win_x_d      = win_x_q;
        win_y_d      = win_y_q;

        if (accept) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = '{bot: bus.pix_in, mid: lb0_rd, top: lb1_rd};
            // The newest pixel is the bottom-right corner; the centre is one up-left.
            win_x_d  = x_q - XW'(1);
            win_y_d  = y_q - YW'(1);
            if (x_q == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        // A frame's window validity is decided at its start and dropped after
        // its last column, so phase 0 always reads as a bubble.
        unique case (phase_q)
            PH_IDLE: win_valid_d = accept && (x_q >= XW'(2)) && (y_q >= YW'(2));
            PH_C2:   win_valid_d = 1'b0;
            default: win_valid_d = win_valid_q;
        endcase

        res_strobe_d = (phase_q == PH_C2) && win_valid_q;
        res_x_d      = res_strobe_d ? win_x_q : res_x_q;
        res_y_d      = res_strobe_d ? win_y_q : res_y_q;
    end

    // Weight banks: the active set only changes on the edge that starts a
    // frame, so one frame never sees two weight sets.
    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < NTAPS; k++) begin
            if (bus.w_we && (bus.w_addr == tap_idx_t'(k))) begin
                shadow_d[k] = bus.w_data;
            end
        end

        commit_load = (phase_q == PH_IDLE) && (commit_pend_q || bus.w_commit);
        if (commit_load) begin
            // Copy from shadow_d so a write on the same edge is included.
            active_d      = shadow_d;
            commit_pend_d = 1'b0;
        end else begin
            active_d      = active_q;
            commit_pend_d = commit_pend_q || bus.w_commit;
        end
    end

    // Column select: phase 1..3 -> window column 0..2; bubbles feed zeros.
    always_comb begin
        data   = '0;
        weight = '0;
        if (win_valid_q) begin
            for (int c = 0; c < KSIZE; c++) begin
                if (int'(phase_q) == c + 1) begin
                    data   = win_q[c];
                    weight = {active_q[2*KSIZE + c], active_q[KSIZE + c], active_q[c]};
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its peers regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q       <= PH_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            win_q         <= '{default: '0};
            win_valid_q   <= 1'b0;
            win_x_q       <= '0;
            win_y_q       <= '0;
            res_strobe_q  <= 1'b0;
            res_x_q       <= '0;
            res_y_q       <= '0;
            shadow_q      <= '{default: '0};
            active_q      <= '{default: '0};
            commit_pend_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            x_q           <= x_d;
            y_q           <= y_d;
            win_q         <= win_d;
            win_valid_q   <= win_valid_d;
            win_x_q       <= win_x_d;
            win_y_q       <= win_y_d;
            res_strobe_q  <= res_strobe_d;
            res_x_q       <= res_x_d;
            res_y_q       <= res_y_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            commit_pend_q <= commit_pend_d;
        end
    end

    assign bus.pix_ready  = (phase_q == PH_IDLE);
    assign bus.phase      = phase_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.res_strobe = res_strobe_q;
    assign bus.res_x      = res_x_q;
    assign bus.res_y      = res_y_q;
    assign bus.data       = data;
    assign bus.weight     = weight;

endmodule

// File: tb/tb_conv_window_feeder.sv
// ---------------------------------------------------------------------------
// tb_conv_window_feeder
// Directed bench for conv_window_feeder on a 4x4 image, with a behavioural
// 3-tap MAC that accumulates over phases 1..3 and holds its result in phase 0.
// ---------------------------------------------------------------------------
module tb_conv_window_feeder;
    import conv_pkg::*;

    localparam int IMG_W = 4;
    localparam int IMG_H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ph_exp = 2'd0;
    int         acc = 0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    conv_window_feeder_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

    conv_window_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // MAC model: counts with the bench's own phase, sums three signed products per cycle.
    always @(negedge clk) begin : mac_model
        int s;
        logic signed [7:0] wb;
        s = 0;
        for (int i = 0; i < 3; i++) begin
            wb = bus.weight[8*i +: 8];
            s  = s + int'(bus.data[8*i +: 8]) * int'(wb);
        end
        if (ph_exp == 2'd1)      acc = s;
        else if (ph_exp != 2'd0) acc = acc + s;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) ph_exp = 2'd0;
        else     ph_exp = ph_exp + 2'd1;
    endtask

    task automatic write_weights(input logic [7:0] w [9]);
        for (int k = 0; k < 9; k++) begin
            bus.w_we   = 1'b1;
            bus.w_addr = 4'(k);
            bus.w_data = w[k];
            step();
        end
        bus.w_we = 1'b0;
    endtask

    task automatic push_pixel(input logic [7:0] v);
        bus.pix_in    = v;
        bus.pix_valid = 1'b1;
        while (ph_exp != 2'd0) step();
        step();
        bus.pix_valid = 1'b0;
    endtask

    // Streams a full 4x4 image and checks every strobe: centre coords and MAC result.
    task automatic stream_image(input logic [7:0] img [16], input int exp_res [4],
                                input int commit_idx, input string tag);
        int ex [4] = '{1, 2, 1, 2};
        int ey [4] = '{1, 1, 2, 2};
        int sent = 0;
        int nstr = 0;
        for (int cyc = 0; cyc < 76; cyc++) begin
            if (bus.res_strobe === 1'b1) begin
                if (nstr >= 4) begin
                    total++; bad++;
                    $display("FAIL %s_extra_strobe: got strobe #%0d want 4 strobes", tag, nstr + 1);
                end else begin
                    total++;
                    if (int'(bus.res_x) !== ex[nstr] || int'(bus.res_y) !== ey[nstr]) begin
                        bad++;
                        $display("FAIL %s_coords[%0d]: got (%0d,%0d) want (%0d,%0d)", tag, nstr,
                                 bus.res_x, bus.res_y, ex[nstr], ey[nstr]);
                    end
                    total++;
                    if (acc !== exp_res[nstr]) begin
                        bad++;
                        $display("FAIL %s_result[%0d]: got %0d want %0d", tag, nstr, acc, exp_res[nstr]);
                    end
                end
                nstr++;
            end
            bus.pix_valid = (sent < 16);
            if (sent < 16) bus.pix_in = img[sent];
            bus.w_commit = (commit_idx >= 0) && (sent == commit_idx + 1) && (ph_exp == 2'd2);
            if (ph_exp == 2'd0 && sent < 16) sent++;
            step();
        end
        bus.pix_valid = 1'b0;
        bus.w_commit  = 1'b0;
        total++;
        if (nstr !== 4) begin
            bad++;
            $display("FAIL %s_strobe_count: got %0d want 4", tag, nstr);
        end
    endtask

    task automatic test_reset();
        logic [56:0] got;
        rst = 1'b1;
        step();
        step();
        got = {bus.phase, bus.win_valid, bus.res_strobe, bus.res_x, bus.res_y,
               bus.data, bus.weight, bus.pix_ready};
        total++;
        if (got !== 57'd1) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", got, 57'd1);
        end
        rst = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'd7;
        repeat (6) step();
        while (ph_exp != 2'd2) step();
        rst = 1'b1;
        #1;
        ph_exp = 2'd0;
        got = {bus.phase, bus.win_valid, bus.res_strobe, bus.res_x, bus.res_y,
               bus.data, bus.weight, bus.pix_ready};
        total++;
        if (got !== 57'd1) begin
            bad++;
            $display("FAIL reset_midrun: got %h want %h", got, 57'd1);
        end
        step();
        rst = 1'b0;
        bus.pix_valid = 1'b0;
    endtask

    task automatic test_stream_uniform();
        logic [7:0] w [9];
        logic [7:0] img [16];
        int exp_res [4] = '{90, 90, 90, 90};
        for (int k = 0; k < 9; k++)  w[k] = 8'd1;
        for (int i = 0; i < 16; i++) img[i] = 8'd10;
        write_weights(w);
        bus.w_commit = 1'b1;
        step();
        bus.w_commit = 1'b0;
        stream_image(img, exp_res, -1, "uniform");
    endtask

    task automatic test_bubble();
        while (ph_exp != 2'd0) step();
        step();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({bus.data, bus.weight, bus.win_valid} !== 49'd0) begin
                bad++;
                $display("FAIL bubble_ph%0d: got data=%h weight=%h win_valid=%b want all 0",
                         i + 1, bus.data, bus.weight, bus.win_valid);
            end
            step();
        end
        total++;
        if (bus.res_strobe !== 1'b0) begin
            bad++;
            $display("FAIL bubble_strobe: got %b want 0", bus.res_strobe);
        end
    endtask

    task automatic test_commit_timing();
        logic [7:0] w [9];
        logic [7:0] img [16];
        int exp_res [4] = '{263, -255, -1, -1};
        for (int k = 0; k < 9; k++)  w[k] = 8'd0;
        w[4] = 8'hFF;
        for (int i = 0; i < 16; i++) img[i] = 8'd1;
        img[6] = 8'd255;   // pixel (x=2, y=1)
        write_weights(w);
        stream_image(img, exp_res, 10, "commit");
    endtask

    task automatic test_ready();
        int accepts = 0;
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'd3;
        for (int i = 0; i < 12; i++) begin
            total++;
            if ({bus.phase, bus.pix_ready} !== {ph_exp, ph_exp == 2'd0}) begin
                bad++;
                $display("FAIL ready_cycle%0d: got phase=%0d ready=%b want phase=%0d ready=%b",
                         i, bus.phase, bus.pix_ready, ph_exp, ph_exp == 2'd0);
            end
            if (bus.pix_ready === 1'b1) accepts++;
            step();
        end
        bus.pix_valid = 1'b0;
        total++;
        if (accepts !== 3) begin
            bad++;
            $display("FAIL ready_accepts: got %0d want 3", accepts);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] img [16];
        int exp_res [4] = '{0, 0, 0, 0};
        int strobes = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 11; i++) push_pixel(8'd1);
        step();
        total++;
        if (bus.win_valid !== 1'b1 || ph_exp !== 2'd2) begin
            bad++;
            $display("FAIL abort_precondition: got win_valid=%b want 1", bus.win_valid);
        end
        rst = 1'b1;
        #1;
        ph_exp = 2'd0;
        total++;
        if ({bus.phase, bus.win_valid, bus.data, bus.weight, bus.pix_ready} !== 52'd1) begin
            bad++;
            $display("FAIL abort_state: got phase=%0d win_valid=%b data=%h weight=%h ready=%b",
                     bus.phase, bus.win_valid, bus.data, bus.weight, bus.pix_ready);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.res_strobe === 1'b1) strobes++;
            step();
        end
        total++;
        if (strobes !== 0) begin
            bad++;
            $display("FAIL abort_strobe: got %0d strobes want 0", strobes);
        end
        for (int i = 0; i < 16; i++) img[i] = 8'd1;
        stream_image(img, exp_res, -1, "after_abort");
    endtask

    initial begin
        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        bus.w_we      = 1'b0;
        bus.w_addr    = '0;
        bus.w_data    = '0;
        bus.w_commit  = 1'b0;
        test_reset();
        test_stream_uniform();
        test_bubble();
        test_commit_timing();
        test_ready();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
